// File: rtl/neopixel_pkg.sv
// Shared types and default timing for the WS2812 one-wire receive path.
// Timing defaults assume a 50 MHz clock.
package neopixel_pkg;

   localparam int WS2812_BITS         = 24;
   localparam int DEF_BIT_THRESH      = 31;
   localparam int DEF_MIN_HIGH        = 5;
   localparam int DEF_MAX_HIGH        = 75;
   localparam int DEF_RESET_LOW       = 2500;
   localparam int DEF_SYNC_STAGES     = 2;

   typedef enum logic [1:0] {
      WAIT_LATCH = 2'd0,
      IDLE       = 2'd1,
      HIGH       = 2'd2,
      LOW        = 2'd3
   } state_t;

   function automatic logic [7:0] sat_inc8(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

endpackage

// File: rtl/neopixel_rx_sync_edge_detect.sv
// Synchronizes an asynchronous line into the clock domain and flags its edges.
// Edge pulses last one cycle and line up with the synchronized level.
module sync_edge_detect #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic async_i,
   output logic level_o,
   output logic rise_o,
   output logic fall_o
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   prev_q;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         sync_q <= '0;
         prev_q <= 1'b0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], async_i};
         prev_q <= sync_q[SYNC_STAGES-1];
      end
   end

   assign level_o = sync_q[SYNC_STAGES-1];
   assign rise_o  = sync_q[SYNC_STAGES-1] & ~prev_q;
   assign fall_o  = ~sync_q[SYNC_STAGES-1] & prev_q;

endmodule

// File: rtl/neopixel_rx.sv
// WS2812 one-wire decoder: pulse-width classifies bits, assembles MSB-first GRB
// pixels and presents them on a valid/ready port with frame-end and error pulses.
module neopixel_rx
   import neopixel_pkg::*;
#(
   parameter int BIT_THRESH  = DEF_BIT_THRESH,
   parameter int MIN_HIGH    = DEF_MIN_HIGH,
   parameter int MAX_HIGH    = DEF_MAX_HIGH,
   parameter int RESET_LOW   = DEF_RESET_LOW,
   parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        one_wire,
   output logic [23:0] pixel_data,
   output logic [7:0]  pixel_index,
   output logic        pixel_valid,
   input  logic        pixel_ready,
   output logic        frame_end,
   output logic        bit_error,
   output logic        overflow,
   output logic        busy,
   output logic [1:0]  dbg_state_o
);

   localparam int LW = $clog2(RESET_LOW + 1);
   localparam int HW = $clog2(MAX_HIGH + 1);

   logic line, rise, fall;

   sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
      .clk_i   (clock),
      .rst_i   (reset),
      .async_i (one_wire),
      .level_o (line),
      .rise_o  (rise),
      .fall_o  (fall)
   );

   state_t      state_q, state_d;
   logic [LW-1:0] low_cnt_q, low_cnt_d;
   logic [HW-1:0] high_cnt_q, high_cnt_d;
   logic [23:0] shift_q, shift_d;
   logic [4:0]  bit_cnt_q, bit_cnt_d;
   logic [7:0]  pix_cnt_q, pix_cnt_d;
   logic [23:0] data_q, data_d;
   logic [7:0]  index_q, index_d;
   logic        valid_q, valid_d;
   logic        frame_end_q, frame_end_d;
   logic        bit_error_q, bit_error_d;
   logic        overflow_q, overflow_d;
   logic        do_shift, shift_bit;
   logic [23:0] word;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q     <= WAIT_LATCH;
         low_cnt_q   <= '0;
         high_cnt_q  <= '0;
         shift_q     <= '0;
         bit_cnt_q   <= '0;
         pix_cnt_q   <= '0;
         data_q      <= '0;
         index_q     <= '0;
         valid_q     <= 1'b0;
         frame_end_q <= 1'b0;
         bit_error_q <= 1'b0;
         overflow_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         low_cnt_q   <= low_cnt_d;
         high_cnt_q  <= high_cnt_d;
         shift_q     <= shift_d;
         bit_cnt_q   <= bit_cnt_d;
         pix_cnt_q   <= pix_cnt_d;
         data_q      <= data_d;
         index_q     <= index_d;
         valid_q     <= valid_d;
         frame_end_q <= frame_end_d;
         bit_error_q <= bit_error_d;
         overflow_q  <= overflow_d;
      end
   end

   // Handshake: a word transfers on any cycle with pixel_valid && pixel_ready;
   // data/index hold while valid is high and ready low, and a completion in
   // the accept cycle reloads the register without raising overflow.
   always_comb begin
      state_d     = state_q;
      low_cnt_d   = low_cnt_q;
      high_cnt_d  = high_cnt_q;
      shift_d     = shift_q;
      bit_cnt_d   = bit_cnt_q;
      pix_cnt_d   = pix_cnt_q;
      data_d      = data_q;
      index_d     = index_q;
      valid_d     = valid_q;
      frame_end_d = 1'b0;
      bit_error_d = 1'b0;
      overflow_d  = 1'b0;
      do_shift    = 1'b0;
      shift_bit   = 1'b0;
      word        = '0;

      if (valid_q && pixel_ready) valid_d = 1'b0;

      case (state_q)
         WAIT_LATCH: begin
            if (line) begin
               low_cnt_d = '0;
            end else if (low_cnt_q == LW'(RESET_LOW - 1)) begin
               state_d   = IDLE;
               low_cnt_d = '0;
            end else begin
               low_cnt_d = low_cnt_q + LW'(1);
            end
         end
         IDLE: begin
            if (rise) begin
               state_d    = HIGH;
               high_cnt_d = HW'(1);
               bit_cnt_d  = '0;
               pix_cnt_d  = '0;
            end
         end
         HIGH: begin
            if (high_cnt_q == HW'(MAX_HIGH)) begin
               bit_error_d = 1'b1;
               bit_cnt_d   = '0;
               low_cnt_d   = '0;
               state_d     = WAIT_LATCH;
            end else if (fall) begin
               if (high_cnt_q < HW'(MIN_HIGH)) begin
                  bit_error_d = 1'b1;
                  bit_cnt_d   = '0;
                  low_cnt_d   = '0;
                  state_d     = WAIT_LATCH;
               end else begin
                  do_shift  = 1'b1;
                  shift_bit = (high_cnt_q >= HW'(BIT_THRESH));
                  low_cnt_d = LW'(1);
                  state_d   = LOW;
               end
            end else begin
               high_cnt_d = high_cnt_q + HW'(1);
            end
         end
         LOW: begin
            if (rise) begin
               state_d    = HIGH;
               high_cnt_d = HW'(1);
            end else if (low_cnt_q == LW'(RESET_LOW - 1)) begin
               frame_end_d = 1'b1;
               low_cnt_d   = '0;
               state_d     = IDLE;
               if (bit_cnt_q != '0) begin
                  bit_error_d = 1'b1;
                  bit_cnt_d   = '0;
               end
            end else begin
               low_cnt_d = low_cnt_q + LW'(1);
            end
         end
         default: state_d = WAIT_LATCH;
      endcase

      if (do_shift) begin
         word    = {shift_q[22:0], shift_bit};
         shift_d = word;
         if (bit_cnt_q == 5'(WS2812_BITS - 1)) begin
            bit_cnt_d = '0;
            pix_cnt_d = sat_inc8(pix_cnt_q);
            if (!valid_q || pixel_ready) begin
               data_d  = word;
               index_d = pix_cnt_q;
               valid_d = 1'b1;
            end else begin
               overflow_d = 1'b1;
            end
         end else begin
            bit_cnt_d = bit_cnt_q + 5'd1;
         end
      end
   end

   assign pixel_data  = data_q;
   assign pixel_index = index_q;
   assign pixel_valid = valid_q;
   assign frame_end   = frame_end_q;
   assign bit_error   = bit_error_q;
   assign overflow    = overflow_q;
   assign busy        = (state_q == HIGH) || (state_q == LOW);
   assign dbg_state_o = state_q;

endmodule

// File: tb/tb_neopixel_rx.sv
// Directed bench for neopixel_rx: drives WS2812 waveforms at 50 MHz and checks
// decoded pixels, handshake, latch, error and reset behaviour.
module tb_neopixel_rx;

   logic        clock = 1'b0;
   logic        reset;
   logic        one_wire;
   logic        pixel_ready;
   logic [23:0] pixel_data;
   logic [7:0]  pixel_index;
   logic        pixel_valid;
   logic        frame_end;
   logic        bit_error;
   logic        overflow;
   logic        busy;
   logic [1:0]  dbg_state;

   neopixel_rx dut (
      .clock       (clock),
      .reset       (reset),
      .one_wire    (one_wire),
      .pixel_data  (pixel_data),
      .pixel_index (pixel_index),
      .pixel_valid (pixel_valid),
      .pixel_ready (pixel_ready),
      .frame_end   (frame_end),
      .bit_error   (bit_error),
      .overflow    (overflow),
      .busy        (busy),
      .dbg_state_o (dbg_state)
   );

   always #10 clock = ~clock;

   int n_checks = 0;
   int n_errors = 0;

   logic [31:0] acc_q[$];
   int fe_n = 0, be_n = 0, ov_n = 0, febe_n = 0;
   logic be_wire = 1'b0;
   int b_acc, b_fe, b_be, b_ov, b_febe;

   always @(negedge clock) begin
      if (pixel_valid && pixel_ready) acc_q.push_back({pixel_index, pixel_data});
      if (frame_end) fe_n++;
      if (bit_error) begin
         be_n++;
         be_wire = one_wire;
      end
      if (overflow) ov_n++;
      if (frame_end && bit_error) febe_n++;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic mark();
      b_acc  = acc_q.size();
      b_fe   = fe_n;
      b_be   = be_n;
      b_ov   = ov_n;
      b_febe = febe_n;
   endtask

   task automatic hold(input logic v, input int n);
      one_wire = v;
      repeat (n) begin
         @(posedge clock);
         #1;
      end
   endtask

   task automatic send_bit(input logic b);
      if (b) begin
         hold(1'b1, 40);
         hold(1'b0, 22);
      end else begin
         hold(1'b1, 17);
         hold(1'b0, 45);
      end
   endtask

   task automatic send_bits(input logic [23:0] w, input int n);
      for (int i = 23; i >= 24 - n; i--) send_bit(w[i]);
   endtask

   task automatic send_word(input logic [23:0] w);
      send_bits(w, 24);
   endtask

   initial begin
      reset       = 1'b1;
      one_wire    = 1'b0;
      pixel_ready = 1'b0;
      repeat (5) @(posedge clock);
      #1;
      check("rst_valid", 32'(pixel_valid), 32'd0);
      check("rst_data", 32'(pixel_data), 32'd0);
      check("rst_index", 32'(pixel_index), 32'd0);
      check("rst_pulses", {29'd0, frame_end, bit_error, overflow}, 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_state", 32'(dbg_state), 32'd0);
      reset = 1'b0;

      // single pixel decode
      hold(1'b0, 2600);
      check("latch_idle", 32'(dbg_state), 32'd1);
      pixel_ready = 1'b1;
      mark();
      send_word(24'hFF0000);
      hold(1'b0, 2600);
      check("dec_count", 32'(acc_q.size() - b_acc), 32'd1);
      check("dec_word", acc_q[b_acc], {8'd0, 24'hFF0000});
      check("dec_fe", 32'(fe_n - b_fe), 32'd1);
      check("dec_be", 32'(be_n - b_be), 32'd0);
      check("dec_ov", 32'(ov_n - b_ov), 32'd0);

      // backpressure: first word held, two drops
      pixel_ready = 1'b0;
      mark();
      send_word(24'h123456);
      send_word(24'hABCDEF);
      send_word(24'h000001);
      hold(1'b0, 2600);
      check("bp_valid", 32'(pixel_valid), 32'd1);
      check("bp_data", 32'(pixel_data), 32'h123456);
      check("bp_index", 32'(pixel_index), 32'd0);
      check("bp_ov", 32'(ov_n - b_ov), 32'd2);
      check("bp_fe", 32'(fe_n - b_fe), 32'd1);
      check("bp_be", 32'(be_n - b_be), 32'd0);
      pixel_ready = 1'b1;
      @(posedge clock);
      #1;
      check("bp_drop", 32'(pixel_valid), 32'd0);
      check("bp_acc_n", 32'(acc_q.size() - b_acc), 32'd1);
      check("bp_acc", acc_q[b_acc], {8'd0, 24'h123456});

      // partial pixel at latch
      mark();
      send_bits(24'hABC000, 12);
      hold(1'b0, 2600);
      check("part_fe", 32'(fe_n - b_fe), 32'd1);
      check("part_be", 32'(be_n - b_be), 32'd1);
      check("part_same", 32'(febe_n - b_febe), 32'd1);
      check("part_acc", 32'(acc_q.size() - b_acc), 32'd0);
      mark();
      send_word(24'h0F0F0F);
      hold(1'b0, 2600);
      check("part_next_n", 32'(acc_q.size() - b_acc), 32'd1);
      check("part_next", acc_q[b_acc], {8'd0, 24'h0F0F0F});

      // glitch mid-pixel, rest of frame ignored
      mark();
      send_bits(24'hA00000, 5);
      hold(1'b1, 3);
      hold(1'b0, 30);
      send_bits(24'hFFF000, 10);
      hold(1'b0, 2600);
      check("gl_be", 32'(be_n - b_be), 32'd1);
      check("gl_fe", 32'(fe_n - b_fe), 32'd0);
      check("gl_acc", 32'(acc_q.size() - b_acc), 32'd0);
      mark();
      send_word(24'h00FF00);
      hold(1'b0, 2600);
      check("gl_next_n", 32'(acc_q.size() - b_acc), 32'd1);
      check("gl_next", acc_q[b_acc], {8'd0, 24'h00FF00});

      // stuck-high line
      mark();
      hold(1'b1, 80);
      hold(1'b0, 2600);
      check("stk_be", 32'(be_n - b_be), 32'd1);
      check("stk_early", 32'(be_wire), 32'd1);
      check("stk_fe", 32'(fe_n - b_fe), 32'd0);

      // completion coincides with accept
      pixel_ready = 1'b0;
      mark();
      send_word(24'h111111);
      send_bits(24'h222222, 23);
      hold(1'b1, 17);
      one_wire = 1'b0;
      @(posedge clock);
      #1;
      @(posedge clock);
      #1;
      pixel_ready = 1'b1;
      @(posedge clock);
      #1;
      pixel_ready = 1'b0;
      hold(1'b0, 43);
      hold(1'b0, 2600);
      check("cc_ov", 32'(ov_n - b_ov), 32'd0);
      check("cc_valid", 32'(pixel_valid), 32'd1);
      check("cc_data", 32'(pixel_data), 32'h222222);
      check("cc_index", 32'(pixel_index), 32'd1);
      check("cc_acc", acc_q[b_acc], {8'd0, 24'h111111});
      pixel_ready = 1'b1;
      @(posedge clock);
      #1;

      // reset in the middle of a frame
      pixel_ready = 1'b0;
      mark();
      send_word(24'h333333);
      send_bits(24'h555555, 10);
      check("mr_pre_busy", 32'(busy), 32'd1);
      check("mr_pre_valid", 32'(pixel_valid), 32'd1);
      reset = 1'b1;
      #1;
      check("mr_valid", 32'(pixel_valid), 32'd0);
      check("mr_data", 32'(pixel_data), 32'd0);
      check("mr_index", 32'(pixel_index), 32'd0);
      check("mr_busy", 32'(busy), 32'd0);
      check("mr_state", 32'(dbg_state), 32'd0);
      @(posedge clock);
      #1;
      reset = 1'b0;
      pixel_ready = 1'b1;
      mark();
      hold(1'b0, 100);
      send_word(24'h777777);
      hold(1'b0, 2600);
      check("mr_ign_acc", 32'(acc_q.size() - b_acc), 32'd0);
      check("mr_ign_fe", 32'(fe_n - b_fe), 32'd0);
      check("mr_ign_valid", 32'(pixel_valid), 32'd0);
      mark();
      send_word(24'h5A5A5A);
      hold(1'b0, 2600);
      check("mr_next_n", 32'(acc_q.size() - b_acc), 32'd1);
      check("mr_next", acc_q[b_acc], {8'd0, 24'h5A5A5A});
      check("mr_next_fe", 32'(fe_n - b_fe), 32'd1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
